// File: rtl/read_operation_ctrl_pkg.sv
// read_operation_ctrl_pkg: shared widths, burst length and FSM encoding for the read controller
//   DATA_W    : width of one register word
//   NUM_REGS  : registers in the file
//   ADDR_W    : register address width
//   BURST_LEN : beats per burst read
//   state_t   : IDLE / BURST controller states
package read_operation_ctrl_pkg;
   localparam int DATA_W    = 32;
   localparam int NUM_REGS  = 8;
   localparam int ADDR_W    = 3;
   localparam int BURST_LEN = 4;
   localparam logic [1:0] CNT_LAST = 2'(BURST_LEN - 1);
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
endpackage

// File: rtl/read_operation_ctrl_read_mux_8to1.sv
// read_mux_8to1: 32-bit 8-to-1 selector, one-hot 3-to-8 decode followed by AND-OR of register words
//   reg_data : concatenated register words, register i at [32i+31:32i]
//   sel      : register address
//   y        : selected word
module read_mux_8to1
   import read_operation_ctrl_pkg::*;
(
   input  logic [NUM_REGS*DATA_W-1:0] reg_data,
   input  logic [ADDR_W-1:0]          sel,
   output logic [DATA_W-1:0]          y
);
   logic [NUM_REGS-1:0] dec;
   assign dec = NUM_REGS'(1) << sel;
   always_comb begin
      y = '0;
      for (int i = 0; i < NUM_REGS; i++)
         y = y | (reg_data[i*DATA_W +: DATA_W] & {DATA_W{dec[i]}});
   end
endmodule

// File: rtl/read_operation_ctrl.sv
// read_operation_ctrl: register-file read controller with single and 4-beat wrapping burst reads
//   clk, reset_n       : clock, asynchronous active-low reset
//   re, burst, Addr    : read request, burst qualifier, start address
//   reg_data           : concatenated register file outputs
//   we, wAddr, wData   : register-file write port, monitored for forwarding only
//   busy               : burst in progress, requests ignored
//   rvalid, rAddr_out, dout : registered read result, two edges after issue
// Optional: READ_OPERATION_CTRL_WRITE_BYPASS_EN forwards a same-edge write to dout.
module read_operation_ctrl
   import read_operation_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       re,
   input  logic                       burst,
   input  logic [ADDR_W-1:0]          Addr,
   input  logic [NUM_REGS*DATA_W-1:0] reg_data,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wAddr,
   input  logic [DATA_W-1:0]          wData,
   output logic                       busy,
   output logic                       rvalid,
   output logic [ADDR_W-1:0]          rAddr_out,
   output logic [DATA_W-1:0]          dout
);
   state_t state, state_nxt;
   logic [ADDR_W-1:0] nxt_addr, nxt_addr_d, iss_addr, s1_addr;
   logic [1:0] cnt, cnt_d;
   logic iss, s1_valid;
   logic [DATA_W-1:0] mux_out, cap_data;

   read_mux_8to1 u_mux (.reg_data(reg_data), .sel(s1_addr), .y(mux_out));

`ifdef READ_OPERATION_CTRL_WRITE_BYPASS_EN
   assign cap_data = (we && wAddr == s1_addr) ? wData : mux_out;
`else
   logic unused_wr;
   assign unused_wr = ^{we, wAddr, wData};
   assign cap_data = mux_out;
`endif

   assign busy = (state == BURST);

   // In BURST the FSM issues its own addresses and ignores the request inputs.
   always_comb begin
      state_nxt  = state;
      nxt_addr_d = nxt_addr;
      cnt_d      = cnt;
      iss        = busy | re;
      iss_addr   = busy ? nxt_addr : Addr;
      if (!busy && re && burst) begin
         state_nxt  = BURST;
         nxt_addr_d = Addr + 1'b1;
         cnt_d      = 2'd1;
      end else if (busy) begin
         nxt_addr_d = nxt_addr + 1'b1;
         cnt_d      = cnt + 1'b1;
         state_nxt  = (cnt == CNT_LAST) ? IDLE : BURST;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         nxt_addr  <= '0;
         cnt       <= '0;
         s1_valid  <= 1'b0;
         s1_addr   <= '0;
         rvalid    <= 1'b0;
         rAddr_out <= '0;
         dout      <= '0;
      end else begin
         state    <= state_nxt;
         nxt_addr <= nxt_addr_d;
         cnt      <= cnt_d;
         s1_valid <= iss;
         if (iss) s1_addr <= iss_addr;
         rvalid   <= s1_valid;
         if (s1_valid) begin
            dout      <= cap_data;
            rAddr_out <= s1_addr;
         end
      end
   end
endmodule

// File: tb/tb_read_operation_ctrl.sv
// tb_read_operation_ctrl: directed self-checking bench for read_operation_ctrl
module tb_read_operation_ctrl;
   logic clk = 0;
   logic reset_n = 0;
   logic re = 0, burst = 0, we = 0;
   logic [2:0] Addr = 0, wAddr = 0;
   logic [255:0] reg_data = '0;
   logic [31:0] wData = 0;
   logic busy, rvalid;
   logic [2:0] rAddr_out;
   logic [31:0] dout;
   int errors = 0, checks = 0;
   logic [31:0] byp_exp;

   read_operation_ctrl u_dut (
      .clk(clk), .reset_n(reset_n), .re(re), .burst(burst), .Addr(Addr),
      .reg_data(reg_data), .we(we), .wAddr(wAddr), .wData(wData),
      .busy(busy), .rvalid(rvalid), .rAddr_out(rAddr_out), .dout(dout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input int i, input logic [31:0] v);
      reg_data[i*32 +: 32] = v;
   endtask

   initial begin
`ifdef READ_OPERATION_CTRL_WRITE_BYPASS_EN
      byp_exp = 32'h55;
`else
      byp_exp = 32'h1;
`endif
      tick(); tick();
      chk("rst_dout", dout, 0);
      chk("rst_rvalid", {31'b0, rvalid}, 0);
      chk("rst_raddr", {29'b0, rAddr_out}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      reset_n = 1;
      tick();
      // single read
      set_reg(3, 32'hDEADBEEF);
      re = 1; burst = 0; Addr = 3;
      tick();
      re = 0;
      chk("single_e0_rvalid", {31'b0, rvalid}, 0);
      tick();
      chk("single_rvalid", {31'b0, rvalid}, 1);
      chk("single_raddr", {29'b0, rAddr_out}, 3);
      chk("single_dout", dout, 32'hDEADBEEF);
      tick();
      chk("single_after_rvalid", {31'b0, rvalid}, 0);
      chk("single_hold_dout", dout, 32'hDEADBEEF);
      // back-to-back singles
      for (int i = 0; i < 8; i++) set_reg(i, 100 + i);
      re = 1; Addr = 0;
      tick();
      Addr = 1;
      tick();
      chk("b2b0_rvalid", {31'b0, rvalid}, 1);
      chk("b2b0_dout", dout, 100);
      Addr = 2;
      tick();
      chk("b2b1_rvalid", {31'b0, rvalid}, 1);
      chk("b2b1_dout", dout, 101);
      re = 0;
      tick();
      chk("b2b2_rvalid", {31'b0, rvalid}, 1);
      chk("b2b2_dout", dout, 102);
      chk("b2b2_raddr", {29'b0, rAddr_out}, 2);
      tick();
      chk("b2b_end_rvalid", {31'b0, rvalid}, 0);
      // burst with wrap, requests at Addr=5 while busy
      re = 1; burst = 1; Addr = 6;
      tick();
      chk("bu_busy0", {31'b0, busy}, 1);
      chk("bu_rvalid0", {31'b0, rvalid}, 0);
      Addr = 5; burst = 0;
      tick();
      chk("bu_busy1", {31'b0, busy}, 1);
      chk("bu_dout6", dout, 106);
      chk("bu_raddr6", {29'b0, rAddr_out}, 6);
      tick();
      chk("bu_busy2", {31'b0, busy}, 1);
      chk("bu_dout7", dout, 107);
      tick();
      chk("bu_busy_end", {31'b0, busy}, 0);
      chk("bu_dout0", dout, 100);
      chk("bu_raddr0", {29'b0, rAddr_out}, 0);
      re = 0;
      tick();
      chk("bu_dout1", dout, 101);
      chk("bu_raddr1", {29'b0, rAddr_out}, 1);
      chk("bu_rvalid3", {31'b0, rvalid}, 1);
      tick();
      chk("bu_no_extra", {31'b0, rvalid}, 0);
      // write bypass
      set_reg(4, 32'h1);
      re = 1; Addr = 4;
      tick();
      re = 0; we = 1; wAddr = 4; wData = 32'h55;
      tick();
      we = 0;
      chk("byp_rvalid", {31'b0, rvalid}, 1);
      chk("byp_dout", dout, byp_exp);
      tick();
      // reset mid-burst
      re = 1; burst = 1; Addr = 2;
      tick();
      re = 0; burst = 0;
      tick();
      chk("mid_dout2", dout, 102);
      tick();
      chk("mid_dout3", dout, 103);
      chk("mid_busy", {31'b0, busy}, 1);
      reset_n = 0;
      #1;
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_rvalid", {31'b0, rvalid}, 0);
      chk("mid_rst_raddr", {29'b0, rAddr_out}, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      tick();
      reset_n = 1;
      tick();
      chk("post_rst_rvalid0", {31'b0, rvalid}, 0);
      tick();
      chk("post_rst_rvalid1", {31'b0, rvalid}, 0);
      chk("post_rst_busy", {31'b0, busy}, 0);
      tick();
      chk("post_rst_rvalid2", {31'b0, rvalid}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
